// File: rtl/serial_frame_pkg.sv
// Shared parameters and state encoding for the serial frame receive controller.
package serial_frame_pkg;

  localparam logic [3:0] PREAMBLE_DEF = 4'b0111;
  localparam int         HDR_W_DEF    = 3;
  localparam int         BYTE_W_DEF   = 8;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3
  } state_e;

endpackage

// File: rtl/serial_frame_ctrl_counter.sv
// Modulo-N up counter with clear; last flags the terminal count N-1.
module frame_mod_counter #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;

  assign last = (cnt_q == W'(N - 1));
  assign cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= last ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Receive sequencer: hunts for the preamble, latches the length header,
// forwards and assembles payload bytes, then flags end of frame.
module serial_frame_ctrl
  import serial_frame_pkg::*;
#(
  parameter logic [3:0] PREAMBLE = PREAMBLE_DEF,
  parameter int         HDR_W    = HDR_W_DEF,
  parameter int         BYTE_W   = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              serin,
  output logic              serout,
  output logic              out_valid,
  output logic              detect,
  output logic [HDR_W-1:0]  hdr,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_strb,
  output logic              done,
  output logic [2:0]        state
);

  localparam int HCW = (HDR_W > 1) ? $clog2(HDR_W) : 1;
  localparam int BCW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [HCW-1:0] HDR_TOP = HCW'(HDR_W - 1);
  localparam logic [BCW-1:0] BIT_TOP = BCW'(BYTE_W - 1);

  state_e              state_q;
  logic [2:0]          preSr_q;
  logic [HDR_W-1:1]    hdrSr_q;
  logic [BYTE_W-1:1]   byteSr_q;
  logic [HDR_W-1:0]    byteCnt_q;
  logic [HDR_W-1:0]    hdr_q;
  logic [BYTE_W-1:0]   byteOut_q;
  logic                serout_q;
  logic                outValid_q;
  logic                detect_q;
  logic                byteStrb_q;
  logic                done_q;

  logic [3:0]          preSr_d;
  logic [HDR_W-1:0]    hdrWord_d;
  logic [BYTE_W-1:0]   byteWord_d;

  logic [HCW-1:0]      hdrCnt;
  logic                hdrLast;
  logic [BCW-1:0]      bitCnt;
  logic                bitLast;

  assign preSr_d    = {preSr_q, serin};
  assign hdrWord_d  = {hdrSr_q, serin};
  assign byteWord_d = {byteSr_q, serin};

  frame_mod_counter #(.N(HDR_W)) u_hdrCnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!en || (state_q != HDR)),
    .inc  (en && (state_q == HDR)),
    .cnt  (hdrCnt),
    .last (hdrLast)
  );

  frame_mod_counter #(.N(BYTE_W)) u_bitCnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!en || (state_q != DATA)),
    .inc  (en && (state_q == DATA)),
    .cnt  (bitCnt),
    .last (bitLast)
  );

  // Pulses and the payload echo default low so every state other than DATA drives them to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      preSr_q    <= '0;
      hdrSr_q    <= '0;
      byteSr_q   <= '0;
      byteCnt_q  <= '0;
      hdr_q      <= '0;
      byteOut_q  <= '0;
      serout_q   <= 1'b0;
      outValid_q <= 1'b0;
      detect_q   <= 1'b0;
      byteStrb_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      serout_q   <= 1'b0;
      outValid_q <= 1'b0;
      detect_q   <= 1'b0;
      byteStrb_q <= 1'b0;
      done_q     <= 1'b0;
      if (!en) begin
        state_q   <= HUNT;
        preSr_q   <= '0;
        byteCnt_q <= '0;
      end else begin
        case (state_q)
          HUNT: begin
            if (preSr_d == PREAMBLE) begin
              state_q  <= HDR;
              detect_q <= 1'b1;
              preSr_q  <= '0;
            end else begin
              preSr_q <= preSr_d[2:0];
            end
          end
          HDR: begin
            if (hdrLast) begin
              hdr_q     <= hdrWord_d;
              byteCnt_q <= '0;
              state_q   <= DATA;
            end else begin
              hdrSr_q[HDR_TOP - hdrCnt] <= serin;
            end
          end
          DATA: begin
            serout_q   <= serin;
            outValid_q <= 1'b1;
            if (bitLast) begin
              byteOut_q  <= byteWord_d;
              byteStrb_q <= 1'b1;
              if (byteCnt_q == hdr_q) begin
                state_q <= DONE;
              end else begin
                byteCnt_q <= byteCnt_q + HDR_W'(1);
              end
            end else begin
              byteSr_q[BIT_TOP - bitCnt] <= serin;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= HUNT;
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

  assign serout    = serout_q;
  assign out_valid = outValid_q;
  assign detect    = detect_q;
  assign hdr       = hdr_q;
  assign byte_out  = byteOut_q;
  assign byte_strb = byteStrb_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl: drives hand-built frames and checks
// pulses, captured bytes and timing against hand-computed values.
module tb_serial_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       serin;
  logic       serout;
  logic       out_valid;
  logic       detect;
  logic [2:0] hdr;
  logic [7:0] byte_out;
  logic       byte_strb;
  logic       done;
  logic [2:0] state;

  int total;
  int bad;
  int cycle;
  int nDetect;
  int nValid;
  int nDone;
  int doneCycle;
  logic [7:0] strbBytes[$];
  int         strbCycles[$];

  serial_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .serin     (serin),
    .serout    (serout),
    .out_valid (out_valid),
    .detect    (detect),
    .hdr       (hdr),
    .byte_out  (byte_out),
    .byte_strb (byte_strb),
    .done      (done),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive serin, step past the edge, then log the pulses the edge produced.
  task automatic applyStimulus(input logic s);
    serin = s;
    @(posedge clk);
    #1;
    cycle++;
    if (detect) nDetect++;
    if (out_valid) nValid++;
    if (byte_strb) begin
      strbBytes.push_back(byte_out);
      strbCycles.push_back(cycle);
    end
    if (done) begin
      nDone++;
      doneCycle = cycle;
    end
  endtask

  task automatic clearMonitor();
    nDetect   = 0;
    nValid    = 0;
    nDone     = 0;
    doneCycle = -1;
    strbBytes.delete();
    strbCycles.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic sendPreamble();
    logic [3:0] p;
    p = 4'b0111;
    for (int i = 3; i >= 0; i--) applyStimulus(p[i]);
  endtask

  task automatic sendHeader(input logic [2:0] h);
    for (int i = 2; i >= 0; i--) applyStimulus(h[i]);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) applyStimulus(b[i]);
  endtask

  function automatic logic [31:0] strbByteAt(input int i);
    return (i < strbBytes.size()) ? 32'(strbBytes[i]) : 32'hFFFF;
  endfunction

  function automatic int strbCycleAt(input int i);
    return (i < strbCycles.size()) ? strbCycles[i] : -100;
  endfunction

  initial begin
    logic [7:0] b1;
    logic [5:0] noise;
    logic [5:0] noiseDet;
    logic [7:0] t6Bytes[8];
    logic [5:0] r5Bits;

    total = 0;
    bad   = 0;
    cycle = 0;
    clearMonitor();
    rst   = 1'b1;
    en    = 1'b0;
    serin = 1'b0;

    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_outs", {24'd0, serout, out_valid, detect, byte_strb, done, hdr}, 32'd0);
    checkOutput("rst_byte", 32'(byte_out), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    idle(2);

    // Frame 1: header 0, single byte B2, with bit-by-bit echo checks.
    clearMonitor();
    sendPreamble();
    checkOutput("t1_detect", 32'(detect), 32'd1);
    checkOutput("t1_state_hdr", 32'(state), 32'd1);
    sendHeader(3'b000);
    checkOutput("t1_state_data", 32'(state), 32'd2);
    checkOutput("t1_hdr", 32'(hdr), 32'd0);
    b1 = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(b1[i]);
      checkOutput("t1_serout", {30'd0, out_valid, serout}, {30'd0, 1'b1, b1[i]});
    end
    checkOutput("t1_strb", 32'(byte_strb), 32'd1);
    checkOutput("t1_byte", 32'(byte_out), 32'hB2);
    checkOutput("t1_state_done", 32'(state), 32'd3);
    applyStimulus(1'b0);
    checkOutput("t1_done", {29'd0, done, out_valid, byte_strb}, 32'b100);
    checkOutput("t1_state_hunt", 32'(state), 32'd0);
    applyStimulus(1'b0);
    checkOutput("t1_done_gone", 32'(done), 32'd0);
    checkOutput("t1_ndetect", 32'(nDetect), 32'd1);
    checkOutput("t1_nvalid", 32'(nValid), 32'd8);

    // Frame 2: two bytes.
    clearMonitor();
    sendPreamble();
    sendHeader(3'b001);
    sendByte(8'hA5);
    sendByte(8'h3C);
    idle(4);
    checkOutput("t2_nstrb", 32'(strbBytes.size()), 32'd2);
    checkOutput("t2_byte0", strbByteAt(0), 32'hA5);
    checkOutput("t2_byte1", strbByteAt(1), 32'h3C);
    checkOutput("t2_gap", 32'(strbCycleAt(1) - strbCycleAt(0)), 32'd8);
    checkOutput("t2_done_at", 32'(doneCycle), 32'(strbCycleAt(1) + 1));
    checkOutput("t2_ndone", 32'(nDone), 32'd1);
    checkOutput("t2_nvalid", 32'(nValid), 32'd16);
    checkOutput("t2_hdr", 32'(hdr), 32'd1);

    // Frame 3: noise ahead of the preamble; only the 6th bit completes a match.
    clearMonitor();
    noise    = 6'b110111;
    noiseDet = 6'b000001;
    for (int i = 5; i >= 0; i--) begin
      applyStimulus(noise[i]);
      checkOutput("t3_detect", 32'(detect), 32'(noiseDet[i]));
    end
    sendHeader(3'b000);
    sendByte(8'h5A);
    idle(3);
    checkOutput("t3_ndetect", 32'(nDetect), 32'd1);
    checkOutput("t3_byte", 32'(byte_out), 32'h5A);
    checkOutput("t3_ndone", 32'(nDone), 32'd1);

    // Frame 4: abort on the 5th payload bit, then a clean frame.
    clearMonitor();
    sendPreamble();
    sendHeader(3'b000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    en = 1'b0;
    applyStimulus(1'b0);
    checkOutput("t4_state_abort", 32'(state), 32'd0);
    checkOutput("t4_valid_abort", 32'(out_valid), 32'd0);
    idle(3);
    en = 1'b1;
    idle(3);
    checkOutput("t4_nstrb", 32'(strbBytes.size()), 32'd0);
    checkOutput("t4_ndone", 32'(nDone), 32'd0);
    checkOutput("t4_byte_kept", 32'(byte_out), 32'h5A);
    sendPreamble();
    sendHeader(3'b000);
    sendByte(8'hC3);
    idle(3);
    checkOutput("t4_byte_new", 32'(byte_out), 32'hC3);
    checkOutput("t4_nstrb_new", 32'(strbBytes.size()), 32'd1);
    checkOutput("t4_ndone_new", 32'(nDone), 32'd1);

    // Frame 6: maximum length, eight bytes.
    clearMonitor();
    t6Bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    sendPreamble();
    sendHeader(3'b111);
    for (int i = 0; i < 8; i++) sendByte(t6Bytes[i]);
    idle(10);
    checkOutput("t6_nstrb", 32'(strbBytes.size()), 32'd8);
    for (int i = 0; i < 8; i++) checkOutput("t6_byte", strbByteAt(i), 32'(t6Bytes[i]));
    checkOutput("t6_hdr", 32'(hdr), 32'd7);
    checkOutput("t6_ndone", 32'(nDone), 32'd1);
    checkOutput("t6_done_at", 32'(doneCycle), 32'(strbCycleAt(7) + 1));
    checkOutput("t6_nvalid", 32'(nValid), 32'd64);

    // Frame 5: reset during the header; preamble must be hunted again.
    clearMonitor();
    sendPreamble();
    applyStimulus(1'b1);
    rst = 1'b1;
    applyStimulus(1'b1);
    checkOutput("t5_state", 32'(state), 32'd0);
    checkOutput("t5_hdr", 32'(hdr), 32'd0);
    checkOutput("t5_byte", 32'(byte_out), 32'd0);
    checkOutput("t5_outs", {27'd0, serout, out_valid, detect, byte_strb, done}, 32'd0);
    rst = 1'b0;
    clearMonitor();
    r5Bits = 6'b101100;
    for (int i = 5; i >= 0; i--) applyStimulus(r5Bits[i]);
    checkOutput("t5_no_detect", 32'(nDetect), 32'd0);
    checkOutput("t5_still_hunt", 32'(state), 32'd0);
    sendPreamble();
    sendHeader(3'b000);
    sendByte(8'h81);
    idle(3);
    checkOutput("t5_byte_new", 32'(byte_out), 32'h81);
    checkOutput("t5_ndone", 32'(nDone), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
